// File: rtl/ddfs_pkg.sv
// Shared DDFS types: clock rates, FTW/sample typedefs and the crossing-FSM states.
package ddfs_pkg;

  localparam int SYSTEM_FREQUENCY   = 50_000_000;
  localparam int SAMPLING_FREQUENCY = 96_000;

  typedef logic [15:0] ftw_q8_8_t;
  typedef logic [7:0]  sample_t;

  typedef enum logic {SEEK_LOW, SEEK_HIGH} xing_state_t;

endpackage

// File: rtl/chirp_frequency_meter_if.sv
// Sample stream in, measurement results out, for the chirp frequency meter.
interface chirp_frequency_meter_if;

  logic                sample_en;
  ddfs_pkg::sample_t   sample;
  logic [15:0]         period;
  ddfs_pkg::ftw_q8_8_t ftw_est;
  logic                valid;
  logic                no_signal;
  logic                overrun;
  logic                busy;

  // source side: drives the sample stream, observes the measurements
  modport master (
    output sample_en, sample,
    input  period, ftw_est, valid, no_signal, overrun, busy
  );

  // meter side
  modport slave (
    input  sample_en, sample,
    output period, ftw_est, valid, no_signal, overrun, busy
  );

endinterface

// File: rtl/chirp_frequency_meter_div.sv
// Sequential restoring divider, one quotient bit per clock, start/busy/done handshake.
// done is a one-cycle pulse; busy covers the iterations plus the done cycle.
module unsigned_divider_seq #(
  parameter int DIVIDEND_W = 17,
  parameter int DIVISOR_W  = 16,
  parameter int QUOT_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [QUOT_W-1:0]     quotient
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

  localparam int CW = $clog2(DIVIDEND_W);

  div_state_t            st_q;
  logic [CW-1:0]         it_q;
  logic [DIVISOR_W-1:0]  rem_q;
  logic [DIVIDEND_W-1:0] quo_q;   // dividend bits shift out the top, quotient bits shift in
  logic [DIVISOR_W-1:0]  dvs_q;
  logic                  busy_q, done_q;

  logic [DIVISOR_W:0]    rem_sh;
  logic [DIVISOR_W-1:0]  rem_sub;
  logic                  ge;

  assign rem_sh  = {rem_q, quo_q[DIVIDEND_W-1]};
  assign ge      = rem_sh >= {1'b0, dvs_q};
  // when ge holds the true difference is below the divisor, so W bits suffice
  assign rem_sub = rem_sh[DIVISOR_W-1:0] - dvs_q;

  // Divider FSM: load on start, iterate DIVIDEND_W times, pulse done, return idle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st_q   <= IDLE;
      it_q   <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (st_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            rem_q  <= '0;
            quo_q  <= dividend;
            dvs_q  <= divisor;
            it_q   <= CW'(DIVIDEND_W - 1);
            busy_q <= 1'b1;
            st_q   <= RUN;
          end
        end
        RUN: begin
          rem_q <= ge ? rem_sub : rem_sh[DIVISOR_W-1:0];
          quo_q <= {quo_q[DIVIDEND_W-2:0], ge};
          if (it_q == '0) begin
            done_q <= 1'b1;
            st_q   <= DONE;
          end else begin
            it_q <= it_q - 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          st_q   <= IDLE;
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quo_q[QUOT_W-1:0];

endmodule

// File: rtl/chirp_frequency_meter.sv
// Measures the period between rising midpoint crossings of the 8-bit sine stream
// and converts it to a Q8.8 tuning word estimate, FTW = 65536 / period.
module chirp_frequency_meter
  import ddfs_pkg::*;
#(
  parameter int MIDPOINT   = 128,
  parameter int HYST       = 8,
  parameter int MIN_PERIOD = 4,
  parameter int MAX_PERIOD = 65535
) (
  input  logic                    clk,
  input  logic                    reset_n,
  chirp_frequency_meter_if.slave  bus
);

  localparam logic [7:0]  LO_TH = 8'(MIDPOINT - HYST);
  localparam logic [7:0]  HI_TH = 8'(MIDPOINT + HYST);
  localparam logic [15:0] MAXP  = 16'(MAX_PERIOD);
  localparam logic [16:0] MINP  = 17'(MIN_PERIOD);

  xing_state_t xst_q;
  logic [15:0] cnt_q, cnt_d;
  logic        first_done_q;
  logic [15:0] per_lat_q;
  logic [15:0] period_q;
  ftw_q8_8_t   ftw_q;
  logic        valid_q, no_signal_q, overrun_q;

  logic        crossing, accept, start, timeout;
  logic [16:0] captured;
  logic        div_busy, div_done;
  logic [15:0] quo;

  assign crossing = bus.sample_en && (xst_q == SEEK_HIGH) && (bus.sample >= HI_TH);
  // 17 bits so a crossing on a saturated counter cannot wrap
  assign captured = {1'b0, cnt_q} + 17'd1;
  assign accept   = crossing && first_done_q && (captured >= MINP);
  assign start    = accept && !div_busy;
  // counter is about to saturate on this strobe; a crossing takes precedence
  assign timeout  = bus.sample_en && !crossing && (cnt_q == MAXP - 16'd1);
  assign cnt_d    = crossing ? 16'd0 : ((cnt_q == MAXP) ? cnt_q : cnt_q + 16'd1);

  unsigned_divider_seq #(
    .DIVIDEND_W (17),
    .DIVISOR_W  (16),
    .QUOT_W     (16)
  ) u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .dividend (17'h1_0000),
    .divisor  (captured[15:0]),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quo)
  );

  // Hysteretic rising-crossing detector; only strobed samples move it
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      xst_q <= SEEK_LOW;
    end else if (bus.sample_en) begin
      case (xst_q)
        SEEK_LOW:  if (bus.sample <= LO_TH) xst_q <= SEEK_HIGH;
        SEEK_HIGH: if (bus.sample >= HI_TH) xst_q <= SEEK_LOW;
        default:   xst_q <= SEEK_LOW;
      endcase
    end
  end

  // Sample counter and arming: first crossing (after reset or timeout) only arms
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      first_done_q <= 1'b0;
    end else if (bus.sample_en) begin
      cnt_q <= cnt_d;
      if (crossing)     first_done_q <= 1'b1;
      else if (timeout) first_done_q <= 1'b0;
    end
  end

  // Result registers: latch period at divide start, publish with the quotient
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      per_lat_q   <= '0;
      period_q    <= '0;
      ftw_q       <= '0;
      valid_q     <= 1'b0;
      no_signal_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      valid_q   <= div_done;
      overrun_q <= accept && div_busy;
      if (start) per_lat_q <= captured[15:0];
      if (div_done) begin
        period_q <= per_lat_q;
        ftw_q    <= quo;
      end
      if (crossing) begin
        no_signal_q <= 1'b0;
      end else if (timeout) begin
        no_signal_q <= 1'b1;
        period_q    <= '0;
        ftw_q       <= '0;
      end
    end
  end

  assign bus.period    = period_q;
  assign bus.ftw_est   = ftw_q;
  assign bus.valid     = valid_q;
  assign bus.no_signal = no_signal_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = div_busy;

endmodule

// File: tb/tb_chirp_frequency_meter.sv
// Scoreboard bench for chirp_frequency_meter: a behavioural model predicts each
// measurement (period, FTW, due cycle) and each overrun when the stimulus is driven.
module tb_chirp_frequency_meter;
  import ddfs_pkg::*;

  logic gclk = 1'b0;
  logic reset_n = 1'b0;
  always #5 gclk = ~gclk;

  chirp_frequency_meter_if bus();

  chirp_frequency_meter dut (
    .clk     (gclk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int due;
    int per;
    int ftw;
  } exp_t;

  exp_t exp_q[$];
  int   ovr_q[$];
  exp_t mon_e;

  int cyc = 0;
  int n_chk = 0, n_err = 0;
  int n_vld = 0, n_ovr = 0, x_ovr = 0;
  int v0;

  // model state
  bit m_hi, m_first, m_nosig;
  int m_cnt, m_free;

  always @(posedge gclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic m_reset();
    m_hi = 0; m_first = 0; m_nosig = 0; m_cnt = 0; m_free = 0;
    exp_q.delete();
    ovr_q.delete();
  endtask

  // one strobed sample, then gap idle cycles carrying junk samples
  task automatic strobe(input logic [7:0] s, input int gap);
    exp_t e;
    int   per;
    @(negedge gclk);
    bus.sample_en = 1'b1;
    bus.sample    = s;
    if (m_hi && s >= 8'd136) begin
      m_hi  = 0;
      per   = m_cnt + 1;
      m_cnt = 0;
      if (!m_first) begin
        m_first = 1;
        m_nosig = 0;
      end else if (per >= 4) begin
        if (cyc < m_free) begin
          ovr_q.push_back(cyc + 1);
          x_ovr++;
        end else begin
          e.due = cyc + 19; e.per = per; e.ftw = 65536 / per;
          exp_q.push_back(e);
          m_free = cyc + 19;
        end
      end
    end else begin
      if (!m_hi && s <= 8'd120) m_hi = 1;
      if (m_cnt < 65535) begin
        m_cnt++;
        if (m_cnt == 65535) begin m_nosig = 1; m_first = 0; end
      end
    end
    repeat (gap) begin
      @(negedge gclk);
      bus.sample_en = 1'b0;
      bus.sample    = 8'($urandom);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge gclk);
      bus.sample_en = 1'b0;
      bus.sample    = 8'($urandom);
    end
  endtask

  task automatic sq(input int lo, input int hi, input int nper, input int gap,
                    input logic [7:0] lv, input logic [7:0] hv);
    repeat (nper) begin
      repeat (lo) strobe(lv, gap);
      repeat (hi) strobe(hv, gap);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_period"}, 32'(bus.period), 0);
    chk({pfx, "_ftw"}, 32'(bus.ftw_est), 0);
    chk({pfx, "_valid"}, 32'(bus.valid), 0);
    chk({pfx, "_nosig"}, 32'(bus.no_signal), 0);
    chk({pfx, "_ovr"}, 32'(bus.overrun), 0);
    chk({pfx, "_busy"}, 32'(bus.busy), 0);
  endtask

  // monitor: every valid/overrun must match the head of its queue, on the due cycle
  always @(negedge gclk) begin
    if (reset_n) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        chk("miss_valid", 32'(cyc), 32'(exp_q[0].due));
        void'(exp_q.pop_front());
      end
      while (ovr_q.size() > 0 && ovr_q[0] < cyc) begin
        chk("miss_ovr", 32'(cyc), 32'(ovr_q[0]));
        void'(ovr_q.pop_front());
      end
      if (bus.valid === 1'b1) begin
        n_vld++;
        if (exp_q.size() == 0) chk("unexp_valid", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("vld_lat", 32'(cyc), 32'(mon_e.due));
          chk("period", 32'(bus.period), 32'(mon_e.per));
          chk("ftw_est", 32'(bus.ftw_est), 32'(mon_e.ftw));
        end
      end
      if (bus.overrun === 1'b1) begin
        n_ovr++;
        if (ovr_q.size() == 0) chk("unexp_ovr", 1, 0);
        else chk("ovr_lat", 32'(cyc), 32'(ovr_q.pop_front()));
      end
    end
  end

  initial begin
    bus.sample_en = 1'b0;
    bus.sample    = '0;
    m_reset();
    repeat (3) @(negedge gclk);
    chk_zero("rst");
    reset_n = 1'b1;

    // square wave 20/236, period 218: arm, then two measurements of 300
    sq(109, 109, 3, 1, 8'd20, 8'd236);
    idle(25);
    chk("t1_nvld", 32'(n_vld), 2);
    chk("t1_period", 32'(bus.period), 218);
    chk("t1_ftw", 32'(bus.ftw_est), 300);

    // period 100 then period 50, no overruns at this spacing
    sq(50, 50, 3, 2, 8'd20, 8'd236);
    sq(25, 25, 3, 2, 8'd20, 8'd236);
    idle(25);
    chk("t2_ftw", 32'(bus.ftw_est), 1310);
    chk("t2_no_ovr", 32'(n_ovr), 0);

    // in-band chatter never crosses, then constant midpoint times out
    v0 = n_vld;
    for (int i = 0; i < 1000; i++) strobe((i % 2) ? 8'd131 : 8'd125, 0);
    idle(25);
    chk("t3_band_nvld", 32'(n_vld), 32'(v0));
    repeat (65535) strobe(8'd128, 0);
    idle(3);
    chk("t3_nosig", 32'(bus.no_signal), 1);
    chk("t3_ftw", 32'(bus.ftw_est), 0);
    chk("t3_period", 32'(bus.period), 0);
    chk("t3_nvld", 32'(n_vld), 32'(v0));

    // continuous strobes, crossings every 4: first re-arms, then 16384 and overruns
    v0 = n_vld;
    sq(2, 2, 10, 0, 8'd20, 8'd236);
    idle(30);
    chk("t4_nosig", 32'(bus.no_signal), 0);
    chk("t4_ftw", 32'(bus.ftw_est), 16384);
    chk("t4_nvld", 32'(n_vld), 32'(v0 + 2));
    chk("t4_novr", 32'(n_ovr), 32'(x_ovr));
    chk("t4_ovr_seen", 32'(n_ovr > 0), 1);

    // glitch: period-3 spike discarded, following 218 period accepted
    repeat (3) strobe(8'd20, 1);
    strobe(8'd236, 1);
    idle(25);
    v0 = n_vld;
    strobe(8'd20, 1);
    strobe(8'd20, 1);
    strobe(8'd236, 1);
    idle(25);
    chk("t5_spike_nvld", 32'(n_vld), 32'(v0));
    repeat (217) strobe(8'd20, 1);
    strobe(8'd236, 1);
    idle(25);
    chk("t5_nvld", 32'(n_vld), 32'(v0 + 1));
    chk("t5_ftw", 32'(bus.ftw_est), 300);

    // reset 10 clk into a division: aborted, and two crossings needed again
    repeat (10) strobe(8'd20, 0);
    strobe(8'd236, 0);
    repeat (9) strobe(8'd236, 0);
    @(negedge gclk);
    reset_n = 1'b0;
    bus.sample_en = 1'b0;
    m_reset();
    @(negedge gclk);
    reset_n = 1'b1;
    chk_zero("t6");
    v0 = n_vld;
    idle(30);
    chk("t6_abort_nvld", 32'(n_vld), 32'(v0));
    sq(109, 109, 2, 1, 8'd20, 8'd236);
    idle(25);
    chk("t6_nvld", 32'(n_vld), 32'(v0 + 1));
    chk("t6_ftw", 32'(bus.ftw_est), 300);

    chk("q_exp_empty", 32'(exp_q.size()), 0);
    chk("q_ovr_empty", 32'(ovr_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_chk, n_err);
    $finish;
  end

endmodule
